// File: rtl/pc_call_sequencer_pkg.sv
// Shared constants for the PC call sequencer:
// request opcodes, FSM states and default sizes.
package pc_call_sequencer_pkg;

  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_FRAMES  = 8;
  localparam int DEF_DEPTH_W = 3;

  typedef enum logic [1:0] {
    OP_STEP = 2'd0,
    OP_JUMP = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_STEP      = 3'd1,
    S_JUMP      = 3'd2,
    S_CALL_PUSH = 3'd3,
    S_CALL_SET  = 3'd4,
    S_RET_POP   = 3'd5,
    S_ERR       = 3'd6
  } state_e;

endpackage

// File: rtl/pc_call_sequencer_if.sv
// Request handshake bundle between a control
// master and the PC call sequencer.
interface pc_call_sequencer_if
  import pc_call_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              req_valid;
  logic              req_ready;
  op_e               req_op;
  logic [ADDR_W-1:0] req_target;

  modport master (
    output req_valid,
    output req_op,
    output req_target,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_target,
    output req_ready
  );
endinterface

// File: rtl/pc_call_sequencer.sv
// Turns STEP/JUMP/CALL/RET requests into strobes
// for the banked PC block, with a shadow depth.
module pc_call_sequencer
  import pc_call_sequencer_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int FRAMES  = DEF_FRAMES,
  parameter int DEPTH_W = DEF_DEPTH_W
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_call_sequencer_if.slave req,
  output logic               done,
  output logic               err,
  input  logic               err_clr,
  output logic [DEPTH_W-1:0] depth,
  output logic               pc_inc,
  output logic               pc_ref_inc,
  output logic               pc_ref_dec,
  output logic               pc_set,
  output logic [ADDR_W-1:0]  pc_set_value,
  input  logic               pc_err
);

  localparam logic [DEPTH_W-1:0] DMAX =
    DEPTH_W'(FRAMES - 1);

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [ADDR_W-1:0]  tgt_q, tgt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               inc_q, inc_d;
  logic               rinc_q, rinc_d;
  logic               rdec_q, rdec_d;
  logic               set_q, set_d;
  logic [ADDR_W-1:0]  val_q, val_d;
  logic               req_rdy;
  logic               err_hit;

  assign req_rdy = (state_q == S_IDLE)
                && !err_q && !pc_err;
  assign req.req_ready = req_rdy;

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    tgt_d   = tgt_q;
    err_hit = 1'b0;
    if (pc_err && state_q != S_ERR) begin
      state_d = S_ERR;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req.req_valid && req_rdy) begin
            tgt_d = req.req_target;
            unique case (req.req_op)
              OP_STEP: state_d = S_STEP;
              OP_JUMP: state_d = S_JUMP;
              OP_CALL: begin
                if (depth_q == DMAX) begin
                  state_d = S_ERR;
                  err_hit = 1'b1;
                end else begin
                  state_d = S_CALL_PUSH;
                end
              end
              OP_RET: begin
                if (depth_q == '0) begin
                  state_d = S_ERR;
                  err_hit = 1'b1;
                end else begin
                  state_d = S_RET_POP;
                end
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
        S_STEP:      state_d = S_IDLE;
        S_JUMP:      state_d = S_IDLE;
        S_CALL_PUSH: begin
          state_d = S_CALL_SET;
          depth_d = depth_q + DEPTH_W'(1);
        end
        S_CALL_SET:  state_d = S_IDLE;
        S_RET_POP: begin
          state_d = S_IDLE;
          depth_d = depth_q - DEPTH_W'(1);
        end
        S_ERR: begin
          if (err_clr && !pc_err) state_d = S_IDLE;
        end
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next state so they
  // appear registered in the cycle the state is live.
  always_comb begin
    inc_d  = 1'b0;
    rinc_d = 1'b0;
    rdec_d = 1'b0;
    set_d  = 1'b0;
    done_d = err_hit;
    unique case (1'b1)
      (state_d == S_STEP): begin
        inc_d  = 1'b1;
        done_d = 1'b1;
      end
      (state_d == S_JUMP): begin
        set_d  = 1'b1;
        done_d = 1'b1;
      end
      (state_d == S_CALL_PUSH): begin
        inc_d  = 1'b1;
        rinc_d = 1'b1;
      end
      (state_d == S_CALL_SET): begin
        set_d  = 1'b1;
        done_d = 1'b1;
      end
      (state_d == S_RET_POP): begin
        rdec_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
    err_d = (state_d == S_ERR);
    val_d = set_d ? tgt_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      inc_q   <= 1'b0;
      rinc_q  <= 1'b0;
      rdec_q  <= 1'b0;
      set_q   <= 1'b0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      inc_q   <= inc_d;
      rinc_q  <= rinc_d;
      rdec_q  <= rdec_d;
      set_q   <= set_d;
      val_q   <= val_d;
    end
  end

  assign done         = done_q;
  assign err          = err_q;
  assign depth        = depth_q;
  assign pc_inc       = inc_q;
  assign pc_ref_inc   = rinc_q;
  assign pc_ref_dec   = rdec_q;
  assign pc_set       = set_q;
  assign pc_set_value = val_q;

endmodule

// File: doc/pc_call_sequencer.md
Name: pc_call_sequencer

Overview:
Control-side driver for the banked program-counter block. It accepts one control-flow request at a time over a valid/ready handshake: STEP, JUMP, CALL or RET. It converts each request into the cycle-accurate pulse sequence on the PC block's control inputs (pc_inc, pc_ref_inc, pc_ref_dec, pc_set, pc_set_value). It keeps a shadow copy of the frame pointer, so it detects call-stack overflow and underflow before issuing any pulse, rather than relying on the PC block's late error flag.

Parameters:
ADDR_W, 9, width of pc_set_value and req_target
FRAMES, 8, number of PC frames in the bank; shadow depth ranges 0..FRAMES-1
DEPTH_W, 3, width of depth output, equal to clog2(FRAMES)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  2  0=STEP, 1=JUMP, 2=CALL, 3=RET
req_target  in  ADDR_W  destination address for JUMP/CALL
done  out  1  one-cycle pulse when a request completes (also on error)
err  out  1  sticky overflow/underflow/mismatch flag
err_clr  in  1  clears err and returns FSM to IDLE
depth  out  DEPTH_W  shadow frame pointer
pc_inc  out  1  to PC block
pc_ref_inc  out  1  to PC block
pc_ref_dec  out  1  to PC block
pc_set  out  1  to PC block
pc_set_value  out  ADDR_W  to PC block
pc_err  in  1  error flag from PC block

Behaviour:
- Reset (async, rst_n=0): state=IDLE, depth=0, err=0, done=0, all pc_* strobes=0, pc_set_value=0.
- Reset asserted mid-sequence aborts the sequence immediately; no partial strobe may persist past reset assertion.
- Strobes are registered outputs, each asserted for exactly one cycle per use.
- Handshake: a request is accepted on a clock edge where req_valid && req_ready.
- req_ready=1 only in IDLE with err=0.
- req_op and req_target are captured at acceptance; later changes on these inputs are ignored.
- States: IDLE, STEP, JUMP, CALL_PUSH, CALL_SET, RET_POP, ERR.
- STEP: one cycle with pc_inc=1, then done; total latency 1 cycle after accept.
- JUMP: one cycle with pc_set=1 and pc_set_value=target, then done.
- CALL (depth<FRAMES-1):
  - CALL_PUSH cycle: pc_inc=1 and pc_ref_inc=1 together. The caller frame advances to its return address while the pointer moves.
  - CALL_SET cycle: pc_set=1, pc_set_value=target, written into the new frame.
  - depth increments at the end of CALL_PUSH; done in CALL_SET. Latency 2 cycles.
- RET (depth>0): RET_POP cycle with pc_ref_dec=1 and depth decrements; done. The caller frame already holds its return address, so no pc_inc is issued.
- CALL at depth==FRAMES-1, or RET at depth==0: no strobes are issued. Go to ERR, set err=1 and pulse done. depth is unchanged.
- pc_err=1 while err=0, in any state: set err=1 and go to ERR. This is a mismatch against the PC block.
- ERR: req_ready=0; the FSM holds until err_clr=1, which clears err and returns to IDLE.
- err_clr in a non-ERR state is ignored.
- Simultaneous err_clr and pc_err: pc_err wins.
- The same strobe is never issued twice in a row.
- pc_ref_inc and pc_ref_dec are never both 1 in the same cycle.
- pc_set and pc_inc are never both 1 in the same cycle.
- depth wraps never; it saturates by construction via the error path.

Decomposition:
- Shared constants header: op encodings (OP_STEP, OP_JUMP, OP_CALL, OP_RET) and FSM state encodings, so the decoder and testbench share them.
- Single module. No sub-module is needed; the strobe register bank is inline.

Test Plan:
- Reset then STEP: accept STEP -> pc_inc pulse on the next cycle, done the same cycle, depth=0, req_ready high again the next cycle.
- JUMP target=9'h1A5 -> one cycle with pc_set=1, pc_set_value=9'h1A5, no other strobes.
- CALL target=9'h040 at depth=0 -> cycle1 pc_inc=1 and pc_ref_inc=1; cycle2 pc_set=1 with value 9'h040 and done; depth=1. Then RET -> pc_ref_dec=1, depth=0.
- Seven CALLs bring depth to 7; an eighth CALL -> no strobes, err=1, done pulse, req_ready=0, depth stays 7. Then err_clr -> err=0, IDLE.
- RET at depth=0 -> err=1, no pc_ref_dec. Then assert rst_n=0 during a CALL_PUSH/CALL_SET sequence -> all outputs return to reset values asynchronously, depth=0.
- Force pc_err=1 during IDLE -> err=1, req_ready=0. err_clr asserted in the same cycle as pc_err -> err stays 1.
